// File: rtl/muladd_dot_seq_pkg.sv
// Shared types and width-legality helpers for the dot-product sequencer.
package muladd_seq_pkg;

    // Sequencer states: wait for command, stream operands, let the MAC settle, offer result.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } seq_state_t;

    // Default widths of the reference configuration.
    localparam int DEF_A_WIDTH   = 8;
    localparam int DEF_B_WIDTH   = 8;
    localparam int DEF_C_WIDTH   = 20;
    localparam int DEF_Q_WIDTH   = 20;
    localparam int DEF_LEN_WIDTH = 8;

    // The bias must fit in the result, and a full product must fit in the result.
    function automatic bit widths_legal(input int a_w, input int b_w, input int c_w,
                                        input int q_w, input int len_w);
        return (a_w > 0) && (b_w > 0) && (len_w > 0) &&
               (c_w > 0) && (c_w <= q_w) && (a_w + b_w <= q_w);
    endfunction

endpackage

// File: rtl/muladd_dot_seq_if.sv
// Command / operand / result handshake bundle between the stream fabric and the sequencer.
interface muladd_dot_seq_if #(
    parameter int A_WIDTH   = 8,
    parameter int B_WIDTH   = 8,
    parameter int C_WIDTH   = 20,
    parameter int Q_WIDTH   = 20,
    parameter int LEN_WIDTH = 8
);
    logic                 cmd_valid;
    logic                 cmd_ready;
    logic [LEN_WIDTH-1:0] cmd_len;
    logic                 cmd_signed;
    logic [C_WIDTH-1:0]   cmd_bias;

    logic                 op_valid;
    logic                 op_ready;
    logic [A_WIDTH-1:0]   op_a;
    logic [B_WIDTH-1:0]   op_b;

    logic                 res_valid;
    logic                 res_ready;
    logic [Q_WIDTH-1:0]   res_data;

    // Fabric side: issues commands and operands, consumes results.
    modport master (
        output cmd_valid, cmd_len, cmd_signed, cmd_bias,
        output op_valid, op_a, op_b,
        output res_ready,
        input  cmd_ready, op_ready, res_valid, res_data
    );

    // Sequencer side.
    modport slave (
        input  cmd_valid, cmd_len, cmd_signed, cmd_bias,
        input  op_valid, op_a, op_b,
        input  res_ready,
        output cmd_ready, op_ready, res_valid, res_data
    );

endinterface

// File: rtl/muladd_dot_seq.sv
// Dot-product sequencer: feeds one external MAC with operand pairs and returns the accumulated sum.
module muladd_dot_seq
    import muladd_seq_pkg::*;
#(
    parameter int A_WIDTH   = DEF_A_WIDTH,
    parameter int B_WIDTH   = DEF_B_WIDTH,
    parameter int C_WIDTH   = DEF_C_WIDTH,
    parameter int Q_WIDTH   = DEF_Q_WIDTH,
    parameter int LEN_WIDTH = DEF_LEN_WIDTH
) (
    input  logic               CLK,
    input  logic               rst,
    muladd_dot_seq_if.slave    bus,
    output logic               busy,
    output logic [A_WIDTH-1:0] mac_A,
    output logic [B_WIDTH-1:0] mac_B,
    output logic [C_WIDTH-1:0] mac_C,
    output logic               mac_ACC,
    output logic               mac_signExtension,
    output logic               mac_ACCout,
    output logic               mac_clr,
    input  logic [Q_WIDTH-1:0] mac_Q
);

    localparam bit WIDTHS_OK = widths_legal(A_WIDTH, B_WIDTH, C_WIDTH, Q_WIDTH, LEN_WIDTH);

    // Refuse to elaborate a configuration where the bias or a product cannot fit the result.
    if (!WIDTHS_OK) begin : g_width_check
        $error("muladd_dot_seq: illegal width parameters");
    end

    seq_state_t           state;
    logic [LEN_WIDTH-1:0] count;
    logic [LEN_WIDTH-1:0] len_q;
    logic                 signed_q;
    logic [C_WIDTH-1:0]   bias_q;
    logic [Q_WIDTH-1:0]   res_data_q;
    logic                 res_valid_q;
    logic                 op_ready_q;
    logic                 busy_q;
    logic                 op_fire;
    logic                 last_op;

    assign op_fire = op_ready_q & bus.op_valid;
    assign last_op = (count == len_q - LEN_WIDTH'(1));

    assign bus.cmd_ready  = (state == IDLE);
    assign bus.op_ready   = op_ready_q;
    assign bus.res_valid  = res_valid_q;
    assign bus.res_data   = res_data_q;
    assign busy           = busy_q;

    assign mac_clr           = (state == IDLE);
    assign mac_C             = bias_q;
    assign mac_signExtension = signed_q;
    assign mac_ACCout        = 1'b1;

    // Controller FSM: command latch, element counter, result capture and handshake flags.
    always_ff @(posedge CLK) begin
        if (rst) begin
            state       <= IDLE;
            count       <= '0;
            len_q       <= '0;
            signed_q    <= 1'b0;
            bias_q      <= '0;
            res_data_q  <= '0;
            res_valid_q <= 1'b0;
            op_ready_q  <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.cmd_valid) begin
                        len_q    <= bus.cmd_len;
                        signed_q <= bus.cmd_signed;
                        bias_q   <= bus.cmd_bias;
                        count    <= '0;
                        busy_q   <= 1'b1;
                        if (bus.cmd_len == '0) begin
                            res_data_q  <= Q_WIDTH'(bus.cmd_bias);
                            res_valid_q <= 1'b1;
                            state       <= DONE;
                        end else begin
                            op_ready_q <= 1'b1;
                            state      <= RUN;
                        end
                    end
                end
                RUN: begin
                    if (op_fire) begin
                        count <= count + LEN_WIDTH'(1);
                        if (last_op) begin
                            op_ready_q <= 1'b0;
                            state      <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    res_data_q  <= mac_Q;
                    res_valid_q <= 1'b1;
                    state       <= DONE;
                end
                DONE: begin
                    if (bus.res_ready) begin
                        res_valid_q <= 1'b0;
                        busy_q      <= 1'b0;
                        state       <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // MAC operand steering: real operands only on a fire, zeros otherwise so the accumulator holds.
    always_comb begin
        mac_A   = '0;
        mac_B   = '0;
        mac_ACC = 1'b0;
        case (state)
            RUN: begin
                mac_ACC = (count != '0);
                if (op_fire) begin
                    mac_A = bus.op_a;
                    mac_B = bus.op_b;
                end
            end
            DRAIN, DONE: begin
                mac_ACC = 1'b1;
            end
            default: begin
                mac_ACC = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_muladd_dot_seq.sv
// Directed self-checking bench for muladd_dot_seq with a behavioural MAC on its mac_* port.
module tb_muladd_dot_seq;

    localparam int AW = 8;
    localparam int BW = 8;
    localparam int CW = 20;
    localparam int QW = 20;
    localparam int LW = 8;

    logic          CLK = 1'b0;
    logic          rst;
    logic          busy;
    logic [AW-1:0] mac_A;
    logic [BW-1:0] mac_B;
    logic [CW-1:0] mac_C;
    logic          mac_ACC;
    logic          mac_signExtension;
    logic          mac_ACCout;
    logic          mac_clr;
    logic [QW-1:0] mac_Q;
    logic [QW-1:0] acc_q = '0;
    logic [QW-1:0] prod;

    int checks = 0;
    int errors = 0;

    muladd_dot_seq_if #(.A_WIDTH(AW), .B_WIDTH(BW), .C_WIDTH(CW), .Q_WIDTH(QW), .LEN_WIDTH(LW)) bus ();

    muladd_dot_seq #(.A_WIDTH(AW), .B_WIDTH(BW), .C_WIDTH(CW), .Q_WIDTH(QW), .LEN_WIDTH(LW)) dut (
        .CLK               (CLK),
        .rst               (rst),
        .bus               (bus.slave),
        .busy              (busy),
        .mac_A             (mac_A),
        .mac_B             (mac_B),
        .mac_C             (mac_C),
        .mac_ACC           (mac_ACC),
        .mac_signExtension (mac_signExtension),
        .mac_ACCout        (mac_ACCout),
        .mac_clr           (mac_clr),
        .mac_Q             (mac_Q)
    );

    always #5 CLK = ~CLK;

    // Behavioural MAC product: sign- or zero-extend both operands, keep the low QW bits.
    always_comb begin
        if (mac_signExtension)
            prod = QW'($signed(mac_A)) * QW'($signed(mac_B));
        else
            prod = QW'(mac_A) * QW'(mac_B);
    end

    // Behavioural MAC accumulator with C-register option off.
    always @(posedge CLK) begin
        if (mac_clr)
            acc_q <= '0;
        else
            acc_q <= prod + (mac_ACC ? acc_q : QW'(mac_C));
    end

    assign mac_Q = acc_q;

    task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic send_cmd(input logic [LW-1:0] len, input logic sgn, input logic [CW-1:0] bias);
        bus.cmd_valid  = 1'b1;
        bus.cmd_len    = len;
        bus.cmd_signed = sgn;
        bus.cmd_bias   = bias;
        #1 check_output("cmd_ready_idle", 32'(bus.cmd_ready), 32'd1);
        @(negedge CLK);
        bus.cmd_valid = 1'b0;
    endtask

    task automatic send_op(input logic [AW-1:0] a, input logic [BW-1:0] b, input int gap, input bit first);
        for (int g = 0; g < gap; g++) begin
            bus.op_valid = 1'b0;
            bus.op_a     = 8'hAA;
            bus.op_b     = 8'h55;
            #1 check_output("bubble_mac_A", 32'(mac_A), 32'd0);
            check_output("bubble_mac_B", 32'(mac_B), 32'd0);
            @(negedge CLK);
        end
        bus.op_valid = 1'b1;
        bus.op_a     = a;
        bus.op_b     = b;
        #1 check_output("op_ready_run", 32'(bus.op_ready), 32'd1);
        check_output("fire_mac_A", 32'(mac_A), 32'(a));
        check_output("fire_mac_B", 32'(mac_B), 32'(b));
        check_output("fire_mac_ACC", 32'(mac_ACC), first ? 32'd0 : 32'd1);
        @(negedge CLK);
        bus.op_valid = 1'b0;
    endtask

    // Called in the cycle after the final fire: expects DRAIN now and DONE one cycle later.
    task automatic take_result(input string tag, input logic [QW-1:0] expected);
        #1 check_output({tag, "_drain_no_valid"}, 32'(bus.res_valid), 32'd0);
        @(negedge CLK);
        check_output({tag, "_res_valid"}, 32'(bus.res_valid), 32'd1);
        check_output({tag, "_res_data"}, 32'(bus.res_data), 32'(expected));
        bus.res_ready = 1'b1;
        @(negedge CLK);
        bus.res_ready = 1'b0;
        check_output({tag, "_back_idle"}, 32'(busy), 32'd0);
    endtask

    initial begin
        rst            = 1'b1;
        bus.cmd_valid  = 1'b0;
        bus.cmd_len    = '0;
        bus.cmd_signed = 1'b0;
        bus.cmd_bias   = '0;
        bus.op_valid   = 1'b0;
        bus.op_a       = '0;
        bus.op_b       = '0;
        bus.res_ready  = 1'b0;
        repeat (2) @(negedge CLK);
        check_output("rst_res_valid", 32'(bus.res_valid), 32'd0);
        check_output("rst_res_data", 32'(bus.res_data), 32'd0);
        check_output("rst_busy", 32'(busy), 32'd0);
        check_output("rst_op_ready", 32'(bus.op_ready), 32'd0);
        check_output("rst_cmd_ready", 32'(bus.cmd_ready), 32'd1);
        check_output("rst_mac_clr", 32'(mac_clr), 32'd1);
        check_output("mac_ACCout", 32'(mac_ACCout), 32'd1);
        rst = 1'b0;
        @(negedge CLK);

        $display("[TB] unsigned N=3 bias=10 back-to-back");
        send_cmd(8'd3, 1'b0, 20'd10);
        check_output("run_mac_C", 32'(mac_C), 32'd10);
        check_output("run_cmd_ready", 32'(bus.cmd_ready), 32'd0);
        check_output("run_busy", 32'(busy), 32'd1);
        send_op(8'd1, 8'd2, 0, 1'b1);
        send_op(8'd3, 8'd4, 0, 1'b0);
        send_op(8'd5, 8'd6, 0, 1'b0);
        take_result("unsigned3", 20'h00036);

        $display("[TB] signed N=2 (-1*2)x2");
        send_cmd(8'd2, 1'b1, 20'd0);
        check_output("signed_ext", 32'(mac_signExtension), 32'd1);
        send_op(8'hFF, 8'h02, 0, 1'b1);
        send_op(8'hFF, 8'h02, 0, 1'b0);
        take_result("signed2", 20'hFFFFC);

        $display("[TB] same pairs unsigned");
        send_cmd(8'd2, 1'b0, 20'd0);
        check_output("unsigned_ext", 32'(mac_signExtension), 32'd0);
        send_op(8'hFF, 8'h02, 0, 1'b1);
        send_op(8'hFF, 8'h02, 0, 1'b0);
        take_result("unsigned2", 20'h003FC);

        $display("[TB] bubbles between pairs");
        send_cmd(8'd3, 1'b0, 20'd10);
        send_op(8'd1, 8'd2, 2, 1'b1);
        send_op(8'd3, 8'd4, 2, 1'b0);
        send_op(8'd5, 8'd6, 2, 1'b0);
        take_result("bubbles", 20'h00036);

        $display("[TB] zero length with back-pressure");
        send_cmd(8'd0, 1'b0, 20'd7);
        for (int i = 0; i < 5; i++) begin
            check_output("zl_res_valid", 32'(bus.res_valid), 32'd1);
            check_output("zl_res_data", 32'(bus.res_data), 32'd7);
            check_output("zl_cmd_ready", 32'(bus.cmd_ready), 32'd0);
            bus.cmd_valid = 1'b1;
            bus.cmd_len   = 8'd1;
            @(negedge CLK);
        end
        bus.cmd_valid = 1'b0;
        bus.res_ready = 1'b1;
        #1 check_output("zl_cmd_ready_hs", 32'(bus.cmd_ready), 32'd0);
        check_output("zl_data_hs", 32'(bus.res_data), 32'd7);
        @(negedge CLK);
        bus.res_ready = 1'b0;
        check_output("zl_cmd_ready_after", 32'(bus.cmd_ready), 32'd1);
        check_output("zl_busy_after", 32'(busy), 32'd0);

        $display("[TB] wrap N=255 0xFF*0xFF");
        send_cmd(8'd255, 1'b0, 20'd0);
        for (int i = 0; i < 255; i++) send_op(8'hFF, 8'hFF, 0, i == 0);
        take_result("wrap", 20'hD02FF);

        $display("[TB] reset mid-run");
        send_cmd(8'd3, 1'b0, 20'd0);
        send_op(8'd1, 8'd2, 0, 1'b1);
        send_op(8'd3, 8'd4, 0, 1'b0);
        rst = 1'b1;
        @(negedge CLK);
        rst = 1'b0;
        check_output("midrst_busy", 32'(busy), 32'd0);
        check_output("midrst_mac_clr", 32'(mac_clr), 32'd1);
        check_output("midrst_op_ready", 32'(bus.op_ready), 32'd0);
        for (int i = 0; i < 3; i++) begin
            check_output("midrst_no_valid", 32'(bus.res_valid), 32'd0);
            @(negedge CLK);
        end
        send_cmd(8'd1, 1'b0, 20'd0);
        send_op(8'd3, 8'd3, 0, 1'b1);
        take_result("after_rst", 20'd9);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
